// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses WRITE/RUN/HALT commands, assembles little-endian
// words into the target memory write ports and drives the core reset.
module boot_loader #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10,
    parameter int N_MEM  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_MEM-1:0]  mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              err
);
    localparam int         BYTES     = XLEN / 8;
    localparam logic [2:0] LAST_BYTE = 3'(BYTES - 1);
    localparam logic [2:0] N_MEM_L   = 3'(N_MEM);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1, S_DATA, S_WR
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        target_reg, target_next;
    logic [7:0]        lo_reg, lo_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [2:0]        idx_reg, idx_next;
    logic [XLEN-1:0]   word_reg, word_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
    logic              core_reg, core_next;
    logic              err_reg, err_next;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            target_reg    <= '0;
            lo_reg        <= '0;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            word_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            core_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            target_reg    <= target_next;
            lo_reg        <= lo_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            word_reg      <= word_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            core_reg      <= core_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        lo_next        = lo_reg;
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        word_next      = word_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        core_next      = core_reg;
        err_next       = err_reg;
        accept         = in_valid && (state_reg != S_WR);

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    case (in_data[7:6])
                        2'b00: begin
                            // Out-of-range target is a protocol error, not a write.
                            if ({1'b0, in_data[1:0]} >= N_MEM_L) begin
                                err_next = 1'b1;
                            end else begin
                                target_next = in_data[1:0];
                                core_next   = 1'b0;
                                state_next  = S_ADDR0;
                            end
                        end
                        2'b01:   core_next = 1'b1;
                        2'b10:   core_next = 1'b0;
                        default: err_next  = 1'b1;
                    endcase
                end
            end
            S_ADDR0: if (accept) begin
                lo_next    = in_data;
                state_next = S_ADDR1;
            end
            S_ADDR1: if (accept) begin
                addr_next  = ADDR_W'({in_data, lo_reg});
                state_next = S_CNT0;
            end
            S_CNT0: if (accept) begin
                lo_next    = in_data;
                state_next = S_CNT1;
            end
            S_CNT1: if (accept) begin
                cnt_next   = {in_data, lo_reg};
                idx_next   = '0;
                state_next = ({in_data, lo_reg} == 16'd0) ? S_IDLE : S_DATA;
            end
            S_DATA: if (accept) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (idx_reg == 3'(b)) word_next[b*8 +: 8] = in_data;
                end
                if (idx_reg == LAST_BYTE) begin
                    // Present the complete word during the WR cycle that follows.
                    idx_next       = '0;
                    mem_addr_next  = addr_reg;
                    mem_wdata_next = word_next;
                    state_next     = S_WR;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            S_WR: begin
                addr_next  = addr_reg + ADDR_W'(1);
                cnt_next   = cnt_reg - 16'd1;
                state_next = (cnt_reg == 16'd1) ? S_IDLE : S_DATA;
            end
            default: state_next = S_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N_MEM; gi++) begin : g_we
        assign mem_we[gi] = (state_reg == S_WR) && (target_reg == 2'(gi));
    end

    assign in_ready   = (state_reg != S_WR);
    assign busy       = (state_reg != S_IDLE);
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign core_rst_n = core_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and random command streams compared
// against a stream-parsing reference model.
module tb_boot_loader;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 10;
    localparam int N_MEM  = 2;
    localparam int BYTES  = XLEN / 8;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [7:0]        in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_MEM-1:0]  mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    boot_loader #(.XLEN(XLEN), .ADDR_W(ADDR_W), .N_MEM(N_MEM)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst_n(core_rst_n), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [N_MEM-1:0]  we;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } wr_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ready_bad = 0;
    logic       m_core = 1'b0;
    logic       m_err  = 1'b0;

    // Record every write strobe; in_ready must be low exactly while a write is strobed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we != '0) got_q.push_back({mem_we, mem_addr, mem_wdata});
            if (in_ready !== (mem_we == '0)) ready_bad++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the whole byte stream as commands and list the writes it implies.
    task automatic model_stim();
        int i, n, a, t;
        logic [7:0] c;
        logic [XLEN-1:0] w;
        wr_t e;
        i = 0;
        while (i < stim.size()) begin
            c = stim[i];
            i++;
            case (c[7:6])
                2'b01: m_core = 1'b1;
                2'b10: m_core = 1'b0;
                2'b11: m_err  = 1'b1;
                default: begin
                    t = int'(c[1:0]);
                    if (t >= N_MEM) begin
                        m_err = 1'b1;
                    end else begin
                        m_core = 1'b0;
                        a = int'(stim[i]) + 256 * int'(stim[i+1]);
                        n = int'(stim[i+2]) + 256 * int'(stim[i+3]);
                        i += 4;
                        for (int k = 0; k < n; k++) begin
                            w = '0;
                            for (int b = 0; b < BYTES; b++) w = w | (XLEN'(stim[i+b]) << (8*b));
                            i += BYTES;
                            e.we   = N_MEM'(1 << t);
                            e.addr = ADDR_W'(a % (1 << ADDR_W));
                            e.data = w;
                            exp_q.push_back(e);
                            a++;
                        end
                    end
                end
            endcase
        end
    endtask

    // Entered just after a falling edge; returns just after the falling edge that follows acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        while (in_ready !== 1'b1 && tries < 16) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 16) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout observed=in_ready low expected=byte accepted within 16 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_stream(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            $display("%s write %0d: we=%b addr=%h data=%h (model addr=%h data=%h)",
                     tag, k, got_q[k].we, got_q[k].addr, got_q[k].data,
                     exp_q[k].addr, exp_q[k].data);
            check({tag, "_write"}, 64'(got_q[k]), 64'(exp_q[k]));
        end
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(m_core));
        check({tag, "_err"}, 64'(err), 64'(m_err));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_ready_vs_we"}, 64'(ready_bad), 64'(0));
        got_q.delete();
        exp_q.delete();
        stim.delete();
    endtask

    task automatic run_stream(input string tag, input int maxgap);
        model_stim();
        foreach (stim[j]) send_byte(stim[j], $urandom_range(0, maxgap));
        finish_stream(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        int r, tgt, cnt;
        logic [15:0] a16;

        // Reset with stray valid bytes
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h40;
        @(negedge clk);
        in_data  = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_values("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("after_reset");

        // Single program-memory write, then RUN
        stim = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
        model_stim();
        foreach (stim[j]) begin
            send_byte(stim[j], 0);
            if (j == 0) begin
                check("single_busy_rise", 64'(busy), 64'(1));
                check("single_core_low", 64'(core_rst_n), 64'(0));
            end
            if (j == 8) begin
                check("single_we", 64'(mem_we), 64'(2'b01));
                check("single_addr", 64'(mem_addr), 64'(0));
                check("single_wdata", 64'(mem_wdata), 64'h0000_0513);
                check("single_ready_wr", 64'(in_ready), 64'(0));
            end
        end
        finish_stream("single");
        send_byte(8'h40, 0);
        check("run_core", 64'(core_rst_n), 64'(1));
        m_core = 1'b1;

        // Address wrap with back-to-back data-memory writes
        stim = {8'h01, 8'hFF, 8'h03, 8'h02, 8'h00};
        for (int k = 0; k < 2 * BYTES; k++) stim.push_back(8'($urandom_range(0, 255)));
        run_stream("wrap", 0);

        // Reserved opcode and out-of-range target, then a valid write
        send_byte(8'h40, 0);
        m_core = 1'b1;
        stim = {8'hC0, 8'h02};
        run_stream("errors", 0);
        check("err_core_kept", 64'(core_rst_n), 64'(1));
        stim = {8'h01, 8'h10, 8'h00, 8'h01, 8'h00};
        for (int k = 0; k < BYTES; k++) stim.push_back(8'($urandom_range(0, 255)));
        run_stream("after_err", 1);

        // Zero-count WRITE and HALT
        send_byte(8'h40, 0);
        check("zc_run", 64'(core_rst_n), 64'(1));
        send_byte(8'h00, 0);
        check("zc_core_fall", 64'(core_rst_n), 64'(0));
        check("zc_busy", 64'(busy), 64'(1));
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("zc_busy_fall", 64'(busy), 64'(0));
        send_byte(8'h40, 0);
        check("zc_run2", 64'(core_rst_n), 64'(1));
        send_byte(8'h80, 0);
        check("zc_halt", 64'(core_rst_n), 64'(0));
        m_core = 1'b0;
        finish_stream("zero_count");

        // Gap-tolerant single write
        stim = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
        model_stim();
        foreach (stim[j]) send_byte(stim[j], 3);
        finish_stream("gaps");

        // Reset after two payload bytes of a word
        stim = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05};
        foreach (stim[j]) send_byte(stim[j], 1);
        stim.delete();
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        m_core = 1'b0;
        m_err  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        finish_stream("mid_reset");

        // Random command streams
        for (int p = 0; p < 12; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      stim.push_back(8'h40 | 8'($urandom_range(0, 63)));
            else if (r == 1) stim.push_back(8'h80 | 8'($urandom_range(0, 63)));
            else if (r == 2) stim.push_back(8'hC0 | 8'($urandom_range(0, 63)));
            else begin
                tgt = (r == 3) ? $urandom_range(2, 3) : $urandom_range(0, 1);
                stim.push_back(8'($urandom_range(0, 15) << 2) | 8'(tgt));
                if (tgt < N_MEM) begin
                    a16 = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) a16[ADDR_W-1:0] = '1;
                    cnt = $urandom_range(0, 3);
                    stim.push_back(a16[7:0]);
                    stim.push_back(a16[15:8]);
                    stim.push_back(8'(cnt));
                    stim.push_back(8'h00);
                    for (int k = 0; k < cnt * BYTES; k++) stim.push_back(8'($urandom_range(0, 255)));
                end
            end
        end
        run_stream("random", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream boot loader that fills the core's program and data memories through their write ports, then releases the core from reset. It is the synthesizable successor of the bench load/release sequence: load memory images, hold the core in reset, then run. It is parametrised in word width, memory depth and number of target memories. It sits between an external byte source (UART/debug bridge) and the memory write ports, beside the core reset input.

## Interface
- XLEN, 32: memory word width in bits. Multiple of 8, range 8..64.
- ADDR_W, 10: word-address width. Range 1..16.
- N_MEM, 2: number of target memories. Target 0 is program memory, target 1 is data memory. Range 1..4.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- mem_we  out  N_MEM  one-hot write strobe, one bit per target.
- mem_addr  out  ADDR_W  word address, shared by all targets.
- mem_wdata  out  XLEN  assembled word, shared by all targets.
- core_rst_n  out  1  core reset, active-low.
- busy  out  1  state is not IDLE.
- err  out  1  sticky protocol-error flag.

## Operation
- A byte is consumed on a rising edge where in_valid && in_ready.
- Command byte, bits[7:6] = opcode:
  - 00 WRITE: bits[1:0] = target.
  - 01 RUN: core_rst_n <= 1.
  - 10 HALT: core_rst_n <= 0.
  - 11 reserved.
  - Bits [5:2] (and [1:0] for non-WRITE opcodes) are ignored.
- WRITE: core_rst_n <= 0 on command acceptance. Then the following fields arrive in order:
  - Start address: 2 bytes, LSB first. The upper 16-ADDR_W bits are ignored.
  - Word count: 2 bytes, LSB first.
  - Payload: count × XLEN/8 bytes. Each word is little-endian; the first byte goes to mem_wdata[7:0].
- States and transitions:
  - IDLE: command byte. RUN/HALT stay in IDLE. WRITE goes to ADDR0.
  - ADDR0 -> ADDR1 -> CNT0 -> CNT1.
  - CNT1: if count == 0, go to IDLE; otherwise go to DATA.
  - DATA: collect XLEN/8 bytes, then go to WR.
  - WR: mem_we[target] = 1 for exactly this cycle. Then address += 1 and count -= 1. If count is now 0, go to IDLE; otherwise go to DATA.
- in_ready = 1 in IDLE, ADDR*, CNT* and DATA. in_ready = 0 in WR.
- Address arithmetic is modulo 2^ADDR_W. From the all-ones address, the next word goes to 0.
- The count is 16-bit unsigned; 65535 is the maximum.
- Errors:
  - Reserved opcode, or WRITE with target >= N_MEM: set err, consume the byte, stay in IDLE.
  - core_rst_n is unchanged on an error.
  - No memory write occurs on an error.
  - err is cleared only by rst_n.
- mem_addr and mem_wdata hold their last values outside WR.
- mem_we is zero outside WR.

## Timing
- Reset values:
  - state IDLE
  - in_ready 1
  - mem_we 0
  - mem_addr 0
  - mem_wdata 0
  - core_rst_n 0
  - busy 0
  - err 0
- Reset asserted mid-transfer: outputs return to the reset values immediately, asynchronously. The partial word is discarded. There is no write.
- Latency: last payload byte of a word accepted at edge k means mem_we is high from edge k to edge k+1, with mem_addr and mem_wdata stable in that cycle.
- Peak rate: 1 word per XLEN/8 + 1 cycles.
- RUN/HALT: core_rst_n changes at the same edge that accepts the command byte.
- WRITE: core_rst_n falls at the edge that accepts the WRITE command byte.
- Idle cycles (in_valid = 0) between any bytes are allowed. State and partial data are held.
- busy rises at the edge accepting a WRITE command. It falls at the edge leaving the final WR, or leaving CNT1 when count == 0.

## Test plan
- Reset: hold rst_n = 0, then release. Check all reset values. in_valid pulses during reset are ignored.
- Single write: send 00 00 00 01 00 13 05 00 00. Expect mem_we = 2'b01 for one cycle, mem_addr = 0, mem_wdata = 0x00000513. Then send 40; core_rst_n = 1 at the next edge.
- Wrap and back-to-back writes, ADDR_W = 10: send 01 FF 03 02 00 followed by 8 data bytes. Expect data-memory writes at addresses 0x3FF then 0x000. in_ready = 0 only during each WR cycle.
- Errors: send C0, then 02 with N_MEM = 2. Expect err = 1, no mem_we, core_rst_n unchanged, state IDLE. A following valid WRITE still completes.
- Count zero and HALT: send 40, then 00 05 00 00 00. Expect core_rst_n to fall at the WRITE command byte and no mem_we. Then 40, then 80, expecting core_rst_n 1 then 0.
- Gaps and reset mid-word: insert 3 idle cycles between each payload byte; expect the same result as the gap-free single write. Assert rst_n after 2 payload bytes; expect no write and the IDLE reset state.
